// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one signed Q-format multiplier between two FIFO-fed channels
// using a round-robin ARB -> MULT -> WRITE transaction sequence.
module mult_arbiter #(
    parameter int DATA_SIZE  = 32,
    parameter int QUANT_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] x0_din,
    input  logic                 x0_empty,
    output logic                 x0_rd_en,
    input  logic [DATA_SIZE-1:0] y0_din,
    input  logic                 y0_empty,
    output logic                 y0_rd_en,
    input  logic [DATA_SIZE-1:0] x1_din,
    input  logic                 x1_empty,
    output logic                 x1_rd_en,
    input  logic [DATA_SIZE-1:0] y1_din,
    input  logic                 y1_empty,
    output logic                 y1_rd_en,
    output logic [DATA_SIZE-1:0] out0_dout,
    input  logic                 out0_full,
    output logic                 out0_wr_en,
    output logic [DATA_SIZE-1:0] out1_dout,
    input  logic                 out1_full,
    output logic                 out1_wr_en,
    output logic                 grant,
    output logic                 busy
);
    typedef enum logic [1:0] {ARB, MULT, WRITE} state_t;
    state_t r_state, w_next;
    logic r_rr, r_grant;
    logic [DATA_SIZE-1:0] r_x, r_y, r_res, r_dout0, r_dout1, w_res;
    logic signed [2*DATA_SIZE-1:0] w_prod;
    logic w_el0, w_el1, w_take, w_sel, w_wr;
    assign w_el0 = !x0_empty && !y0_empty && !out0_full;
    assign w_el1 = !x1_empty && !y1_empty && !out1_full;
    assign w_prod = $signed(r_x) * $signed(r_y);
    assign w_res = DATA_SIZE'(w_prod >>> QUANT_BITS);
    always_comb begin
        w_next = r_state;
        w_take = 1'b0;
        w_sel = r_rr;
        w_wr = 1'b0;
        case (r_state)
            ARB: begin
                w_take = w_el0 || w_el1;
                w_sel = (w_el0 && w_el1) ? r_rr : w_el1;
                w_next = w_take ? MULT : ARB;
            end
            MULT: w_next = WRITE;
            WRITE: begin
                w_wr = r_grant ? !out1_full : !out0_full;
                w_next = w_wr ? ARB : WRITE;
            end
            default: w_next = ARB;
        endcase
    end
    // Strobes are masked by reset so an in-flight transaction never pops or pushes.
    assign x0_rd_en = w_take && !w_sel && !reset;
    assign y0_rd_en = x0_rd_en;
    assign x1_rd_en = w_take && w_sel && !reset;
    assign y1_rd_en = x1_rd_en;
    assign out0_wr_en = w_wr && !r_grant && !reset;
    assign out1_wr_en = w_wr && r_grant && !reset;
    assign out0_dout = (r_state == WRITE && !r_grant) ? r_res : r_dout0;
    assign out1_dout = (r_state == WRITE && r_grant) ? r_res : r_dout1;
    assign grant = r_grant;
    assign busy = r_state != ARB;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ARB;
            r_rr <= 1'b0;
            r_grant <= 1'b0;
            r_x <= '0;
            r_y <= '0;
            r_res <= '0;
            r_dout0 <= '0;
            r_dout1 <= '0;
        end else begin
            r_state <= w_next;
            if (w_take) begin
                r_x <= w_sel ? x1_din : x0_din;
                r_y <= w_sel ? y1_din : y0_din;
                r_grant <= w_sel;
                if (w_el0 && w_el1) r_rr <= !r_rr;
            end
            if (r_state == MULT) r_res <= w_res;
            if (out0_wr_en) r_dout0 <= r_res;
            if (out1_wr_en) r_dout1 <= r_res;
        end
    end
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed vectors, multi-cycle corner sequences and a randomized
// run against a queue-based transaction model of the two-channel multiplier arbiter.
module tb_mult_arbiter;
    logic clock = 1'b0, reset = 1'b1;
    logic [31:0] x0_din = '0, y0_din = '0, x1_din = '0, y1_din = '0;
    logic x0_empty = 1'b1, y0_empty = 1'b1, x1_empty = 1'b1, y1_empty = 1'b1;
    logic out0_full = 1'b0, out1_full = 1'b0;
    logic x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en, out0_wr_en, out1_wr_en, grant, busy;
    logic [31:0] out0_dout, out1_dout;
    int n_cmp = 0, n_bad = 0;
    always #5 clock = ~clock;

    mult_arbiter dut (
        .clock(clock), .reset(reset),
        .x0_din(x0_din), .x0_empty(x0_empty), .x0_rd_en(x0_rd_en),
        .y0_din(y0_din), .y0_empty(y0_empty), .y0_rd_en(y0_rd_en),
        .x1_din(x1_din), .x1_empty(x1_empty), .x1_rd_en(x1_rd_en),
        .y1_din(y1_din), .y1_empty(y1_empty), .y1_rd_en(y1_rd_en),
        .out0_dout(out0_dout), .out0_full(out0_full), .out0_wr_en(out0_wr_en),
        .out1_dout(out1_dout), .out1_full(out1_full), .out1_wr_en(out1_wr_en),
        .grant(grant), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Q10 product of two signed words, truncated to 32 bits.
    function automatic logic [31:0] ref_q(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 32'(p >>> 10);
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] r;
        r = $urandom;
        return r[31] ? r : {{20{r[11]}}, r[11:0]};
    endfunction

    typedef struct {
        bit ch;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] exp;
    } vec_t;

    // One isolated transaction on a single channel: pop at t, nothing at t+1, push at t+2.
    task automatic run_txn(input bit ch, input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
        @(posedge clock); #1;
        if (ch) begin x1_din = x; y1_din = y; x1_empty = 0; y1_empty = 0; end
        else begin x0_din = x; y0_din = y; x0_empty = 0; y0_empty = 0; end
        @(negedge clock);
        chk("txn_rd_sel", ch ? {x1_rd_en, y1_rd_en} : {x0_rd_en, y0_rd_en}, 2'b11);
        chk("txn_rd_other", ch ? {x0_rd_en, y0_rd_en} : {x1_rd_en, y1_rd_en}, 2'b00);
        @(posedge clock); #1;
        {x0_empty, y0_empty, x1_empty, y1_empty} = 4'hF;
        @(negedge clock);
        chk("txn_t1_busy_grant", {busy, grant}, {1'b1, ch});
        chk("txn_t1_strobes", {x0_rd_en, x1_rd_en, out0_wr_en, out1_wr_en}, 4'h0);
        @(negedge clock);
        chk("txn_t2_wr", {out1_wr_en, out0_wr_en}, ch ? 2'b10 : 2'b01);
        chk("txn_t2_rd", {x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en}, 4'h0);
        chk("txn_t2_dout", ch ? out1_dout : out0_dout, exp);
        @(negedge clock);
        chk("txn_idle_busy", busy, 1'b0);
        chk("txn_hold_dout", ch ? out1_dout : out0_dout, exp);
    endtask

    // Randomized phase model: per-channel operand queues, a round-robin pointer and one
    // outstanding transaction; pops are taken at the negedge ahead of the edge that consumes them.
    logic [31:0] qx0[$], qy0[$], qx1[$], qy1[$];
    bit rnd_on = 0, m_busy = 0, m_rr = 0, m_ch = 0;
    int m_age = 0, rnd_txns = 0;
    logic [31:0] m_exp;

    always @(negedge clock) if (rnd_on) begin
        bit e0, e1, ch, w;
        e0 = !x0_empty && !y0_empty && !out0_full;
        e1 = !x1_empty && !y1_empty && !out1_full;
        if (!m_busy) begin
            chk("rnd_idle_wr", {out0_wr_en, out1_wr_en}, 2'b00);
            if (e0 || e1) begin
                ch = (e0 && e1) ? m_rr : e1;
                if (e0 && e1) m_rr = !m_rr;
                chk("rnd_rd", {x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en}, ch ? 4'b0011 : 4'b1100);
                if (ch) begin m_exp = ref_q(qx1.pop_front(), qy1.pop_front()); end
                else begin m_exp = ref_q(qx0.pop_front(), qy0.pop_front()); end
                m_busy = 1; m_ch = ch; m_age = 0;
            end else chk("rnd_no_rd", {x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en}, 4'h0);
        end else begin
            m_age++;
            chk("rnd_busy_rd", {x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en}, 4'h0);
            w = m_age >= 2 && !(m_ch ? out1_full : out0_full);
            chk("rnd_wr", {out1_wr_en, out0_wr_en}, {w && m_ch, w && !m_ch});
            if (w) begin
                chk("rnd_dout", m_ch ? out1_dout : out0_dout, m_exp);
                m_busy = 0;
                rnd_txns++;
            end
        end
    end

    task automatic drive_rnd();
        x0_empty = qx0.size() == 0; x0_din = x0_empty ? $urandom : qx0[0];
        y0_empty = qy0.size() == 0; y0_din = y0_empty ? $urandom : qy0[0];
        x1_empty = qx1.size() == 0; x1_din = x1_empty ? $urandom : qx1[0];
        y1_empty = qy1.size() == 0; y1_din = y1_empty ? $urandom : qy1[0];
    endtask

    initial begin
        vec_t vecs[7];
        int guard;
        vecs[0] = '{0, 32'h0000_0800, 32'h0000_0C00, 32'h0000_1800};
        vecs[1] = '{1, 32'hFFFF_FC00, 32'h0000_0800, 32'hFFFF_F800};
        vecs[2] = '{0, 32'h0000_0C00, 32'h0000_0C00, 32'h0000_2400};
        vecs[3] = '{1, 32'h7FFF_FFFF, 32'h0000_0002, 32'h003F_FFFF};
        vecs[4] = '{0, 32'hFFFF_F000, 32'hFFFF_F000, 32'h0000_4000};
        vecs[5] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
        vecs[6] = '{0, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_state", {busy, grant, x0_rd_en, x1_rd_en, out0_wr_en, out1_wr_en}, 6'h0);
        chk("reset_dout", out0_dout | out1_dout, 32'h0);
        // Both channels eligible continuously: grants must alternate, one result per 3 cycles.
        @(posedge clock); #1;
        reset = 0;
        x0_din = 32'h0000_0800; y0_din = 32'h0000_0C00;
        x1_din = 32'hFFFF_FC00; y1_din = 32'h0000_0800;
        {x0_empty, y0_empty, x1_empty, y1_empty} = 4'h0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("rr_rd", {x0_rd_en, y0_rd_en, x1_rd_en, y1_rd_en}, k[0] ? 4'b0011 : 4'b1100);
            @(negedge clock);
            chk("rr_grant", grant, k[0]);
            chk("rr_t1_wr", {out0_wr_en, out1_wr_en}, 2'b00);
            @(negedge clock);
            chk("rr_wr", {out1_wr_en, out0_wr_en}, k[0] ? 2'b10 : 2'b01);
            chk("rr_dout", k[0] ? out1_dout : out0_dout, k[0] ? 32'hFFFF_F800 : 32'h0000_1800);
        end
        // Fifth grant goes to ch0, then reset lands while it is in MULT.
        @(negedge clock);
        chk("rr_rd5", {x0_rd_en, x1_rd_en}, 2'b10);
        @(posedge clock); #1;
        reset = 1;
        {x0_empty, y0_empty, x1_empty, y1_empty} = 4'hF;
        @(negedge clock);
        chk("rst_mult_strobes", {x0_rd_en, x1_rd_en, out0_wr_en, out1_wr_en}, 4'h0);
        @(posedge clock); #1;
        reset = 0;
        repeat (3) begin
            @(negedge clock);
            chk("rst_after_ctl", {busy, grant, out0_wr_en, out1_wr_en}, 4'h0);
            chk("rst_after_dout", out0_dout | out1_dout, 32'h0);
        end
        @(posedge clock); #1;
        {x0_empty, y0_empty, x1_empty, y1_empty} = 4'h0;
        @(negedge clock);
        chk("rst_rr_ch0_first", {x0_rd_en, x1_rd_en}, 2'b10);
        @(posedge clock); #1;
        {x0_empty, y0_empty, x1_empty, y1_empty} = 4'hF;
        @(negedge clock);
        @(negedge clock);
        chk("rst_rr_wr", {out1_wr_en, out0_wr_en}, 2'b01);
        chk("rst_rr_dout", out0_dout, 32'h0000_1800);
        // Isolated single-channel vectors.
        for (int i = 0; i < 7; i++) run_txn(vecs[i].ch, vecs[i].x, vecs[i].y, vecs[i].exp);
        // Output full for 5 WRITE cycles stalls the push until full falls.
        @(posedge clock); #1;
        x0_din = 32'h0000_0800; y0_din = 32'h0000_0800;
        x0_empty = 0; y0_empty = 0;
        @(negedge clock);
        chk("stall_rd", {x0_rd_en, y0_rd_en}, 2'b11);
        @(posedge clock); #1;
        x0_empty = 1; y0_empty = 1; out0_full = 1;
        @(negedge clock);
        chk("stall_mult_wr", out0_wr_en, 1'b0);
        repeat (5) begin
            @(negedge clock);
            chk("stall_hold", {out0_wr_en, out1_wr_en, busy, x0_rd_en}, 4'b0010);
        end
        @(posedge clock); #1;
        out0_full = 0;
        @(negedge clock);
        chk("stall_release_wr", out0_wr_en, 1'b1);
        chk("stall_release_dout", out0_dout, 32'h0000_1000);
        @(negedge clock);
        chk("stall_back_arb", {busy, out0_wr_en}, 2'b00);
        // Randomized phase from a fresh reset so the model pointer starts at channel 0.
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        reset = 0;
        rnd_on = 1;
        repeat (600) begin
            @(posedge clock); #1;
            if (qx0.size() < 4 && $urandom_range(1)) qx0.push_back(rnd_word());
            if (qy0.size() < 4 && $urandom_range(1)) qy0.push_back(rnd_word());
            if (qx1.size() < 4 && $urandom_range(1)) qx1.push_back(rnd_word());
            if (qy1.size() < 4 && $urandom_range(1)) qy1.push_back(rnd_word());
            out0_full = $urandom_range(3) == 0;
            out1_full = $urandom_range(3) == 0;
            drive_rnd();
        end
        out0_full = 0;
        out1_full = 0;
        guard = 0;
        while (guard < 100 && (m_busy || (qx0.size() > 0 && qy0.size() > 0) || (qx1.size() > 0 && qy1.size() > 0))) begin
            @(posedge clock); #1;
            drive_rnd();
            guard++;
        end
        chk("rnd_drain_timeout", guard < 100, 1'b1);
        @(negedge clock);
        rnd_on = 0;
        chk("rnd_activity", rnd_txns >= 50, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: DATA_SIZE, default 32, width of every operand and result word.
REQ-002 Parameter: QUANT_BITS, default 10, arithmetic right shift applied to each raw product (Q10 fixed point).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high; the ports are named clock and reset.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 xN_din  input  DATA_SIZE  channel N (N=0,1) x operand, show-ahead FIFO head, valid while xN_empty=0.
REQ-007 xN_empty  input  1  channel N x FIFO empty.
REQ-008 xN_rd_en  output  1  channel N x FIFO pop.
REQ-009 yN_din, yN_empty, yN_rd_en  input/input/output  DATA_SIZE/1/1  channel N y operand FIFO, same semantics as x.
REQ-010 outN_dout  output  DATA_SIZE  channel N result word.
REQ-011 outN_full  input  1  channel N output FIFO full.
REQ-012 outN_wr_en  output  1  channel N output FIFO push.
REQ-013 grant  output  1  channel currently owning the multiplier.
REQ-014 busy  output  1  high in any state other than ARB.

Function
REQ-015 The block SHALL share one signed multiplier between channels 0 and 1 using an FSM with states ARB, MULT, WRITE.
REQ-016 Channel N SHALL be eligible in ARB when xN_empty=0, yN_empty=0 and outN_full=0.
REQ-017 In ARB with exactly one channel eligible, the block SHALL grant that channel.
REQ-018 In ARB with both channels eligible, the block SHALL grant the channel selected by a 1-bit round-robin pointer, which SHALL then point at the other channel.
REQ-019 On grant, in the same cycle the block SHALL assert xN_rd_en and yN_rd_en together for exactly one cycle, register xN_din and yN_din, register grant, and go to MULT.
REQ-020 With no channel eligible, the block SHALL stay in ARB with all rd_en and wr_en low.
REQ-021 MULT SHALL register result = (signed x * signed y) arithmetically shifted right by QUANT_BITS, truncated to the low DATA_SIZE bits, then go to WRITE.
REQ-022 WRITE SHALL drive outN_dout with the result and assert outN_wr_en only for the granted N and only while outN_full=0.
REQ-023 WRITE SHALL hold (stall) while outN_full=1, asserting no wr_en, and SHALL return to ARB in the cycle wr_en is asserted.
REQ-024 Latency SHALL be rd_en in cycle t, wr_en in cycle t+2 absent stall; minimum throughput is 1 result per 3 cycles.
REQ-025 xN_rd_en and yN_rd_en SHALL always be identical, so a single FIFO feeding both operands (squaring) through an AND of the two rd_en signals pops once.
REQ-026 The non-granted channel's rd_en and wr_en SHALL be low in every cycle.
REQ-027 The block SHALL assert at most one pop pair and one push per transaction; operands are never re-read.
REQ-028 outN_dout SHALL hold its last written value between writes.

Reset
REQ-029 On reset the block SHALL enter ARB with all rd_en and wr_en at 0, outN_dout at 0, grant at 0, busy at 0, round-robin pointer at 0 (channel 0 first), and operand and result registers at 0.
REQ-030 Reset in MULT or WRITE SHALL discard the in-flight transaction, with no wr_en in the reset cycle or after it.

Verification
REQ-031 Only ch0 is fed x=0x00000800 (2.0) and y=0x00000C00 (3.0) -> x0/y0_rd_en in cycle t, out0_wr_en in cycle t+2, out0_dout=0x00001800.
REQ-032 Ch1 is fed x=0xFFFFFC00 (-1.0) and y=0x00000800 -> out1_dout=0xFFFFF800.
REQ-033 Both channels are held eligible continuously from reset -> grant sequence 0,1,0,1, one result every 3 cycles, no cross-channel writes.
REQ-034 out0_full=1 in WRITE for 5 cycles -> no wr_en, busy=1, state held; out0_wr_en in the cycle full falls.
REQ-035 Reset asserted in MULT -> no wr_en follows, all outputs 0; the next transaction grants ch0 first.
REQ-036 Ch0 x/y are tied to one FIFO holding 0x00000C00 -> exactly one pop, out0_dout=0x00002400.
